// File: rtl/bip_host_if.sv
// bip_host_if: byte-framed UART host command interface for the BIP program/data memories
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   d_in, rx_done               received UART byte and its one-cycle strobe
//   tx_start, d_out, tx_done    transmit strobe, byte to send (held until tx_done), send-complete strobe
//   WrPM, WrDM, RdDM, reset_bip one-cycle command strobes, at most one high per cycle
//   outAddr, outData, inData    memory address, write data, read data (valid one cycle after RdDM)
//   leds                        {state, last opcode}
// Frame: opcode, ceil(ADDR_W/8) address bytes, DATA_W/8 data bytes, multi-byte fields MSB first.
// Optional: define BIP_HOST_IF_CHECKSUM_EN to require a trailing XOR-of-frame checksum byte.
module bip_host_if #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        d_in,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] inData,
    output logic              tx_start,
    output logic [7:0]        d_out,
    output logic              WrPM,
    output logic              WrDM,
    output logic              RdDM,
    output logic              reset_bip,
    output logic [ADDR_W-1:0] outAddr,
    output logic [DATA_W-1:0] outData,
    output logic [7:0]        leds
);
    localparam int NA = (ADDR_W + 7) / 8;
    localparam int ND = DATA_W / 8;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] OP_WRPM = 8'h01;
    localparam logic [7:0] OP_WRDM = 8'h02;
    localparam logic [7:0] OP_RDDM = 8'h03;
    localparam logic [7:0] OP_RSTB = 8'h04;
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] NAK     = 8'h15;

    typedef enum logic [3:0] {IDLE, ADDR, DATA, CHK, EXEC, RDWAIT, TX, TXWAIT} state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [TW-1:0]     to_q, to_d;
    logic [ADDR_W-1:0] abuf_q, abuf_d, addr_q, addr_d;
    logic [DATA_W-1:0] dbuf_q, dbuf_d, data_q, data_d, resp_q, resp_d;
    logic [7:0]        dout_q, dout_d;
    logic [2:0]        left_q, left_d;
    logic              payload, expire;

`ifdef BIP_HOST_IF_CHECKSUM_EN
    // Running XOR of the opcode and payload bytes; the opcode restarts it.
    logic [7:0] chk_q;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            chk_q <= '0;
        else if (rx_done && state_q inside {IDLE, ADDR, DATA})
            chk_q <= (state_q == IDLE ? 8'h00 : chk_q) ^ d_in;
    localparam state_t AFTER = CHK;
`else
    localparam state_t AFTER = EXEC;
`endif

    assign payload = state_q inside {ADDR, DATA, CHK};
    assign expire  = payload && !rx_done && to_q == TW'(TIMEOUT_CYC - 1);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        to_d    = payload && !rx_done ? to_q + TW'(1) : '0;
        abuf_d  = abuf_q;
        dbuf_d  = dbuf_q;
        addr_d  = addr_q;
        data_d  = data_q;
        resp_d  = resp_q;
        dout_d  = dout_q;
        left_d  = left_q;
        case (state_q)
            IDLE: if (rx_done) begin
                cnt_d = '0;
                if (d_in inside {OP_WRPM, OP_WRDM, OP_RDDM}) begin
                    op_d    = d_in[3:0];
                    state_d = ADDR;
                end else if (d_in == OP_RSTB) begin
                    op_d    = d_in[3:0];
                    state_d = AFTER;
                end else begin
                    dout_d  = NAK;
                    left_d  = '0;
                    state_d = TX;
                end
            end
            ADDR: if (rx_done) begin
                // Shifting through an ADDR_W register drops the unused upper address bits.
                abuf_d = ADDR_W'({abuf_q, d_in});
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'(NA - 1)) begin
                    cnt_d   = '0;
                    state_d = {4'h0, op_q} == OP_RDDM ? AFTER : DATA;
                end
            end else if (expire) begin
                state_d = IDLE;
            end
            DATA: if (rx_done) begin
                dbuf_d = DATA_W'({dbuf_q, d_in});
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'(ND - 1)) begin
                    cnt_d   = '0;
                    state_d = AFTER;
                end
            end else if (expire) begin
                state_d = IDLE;
            end
            CHK: begin
`ifdef BIP_HOST_IF_CHECKSUM_EN
                if (rx_done) begin
                    if (d_in == chk_q) begin
                        state_d = EXEC;
                    end else begin
                        dout_d  = 8'hEE;
                        left_d  = '0;
                        state_d = TX;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            EXEC: begin
                dout_d  = ACK;
                left_d  = '0;
                state_d = {4'h0, op_q} == OP_RDDM ? RDWAIT : TX;
            end
            RDWAIT: begin
                // First response byte goes out now; the rest wait in resp_q, MSB first.
                dout_d  = inData[DATA_W-1 -: 8];
                resp_d  = inData << 8;
                left_d  = 3'(ND - 1);
                state_d = TX;
            end
            TX: state_d = TXWAIT;
            TXWAIT: if (tx_done) begin
                if (left_q != 3'd0) begin
                    dout_d  = resp_q[DATA_W-1 -: 8];
                    resp_d  = resp_q << 8;
                    left_d  = left_q - 3'd1;
                    state_d = TX;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Memory-facing registers change only as a complete frame enters EXEC.
        if (state_d == EXEC) begin
            if ({4'h0, op_d} != OP_RSTB)
                addr_d = abuf_d;
            if ({4'h0, op_d} inside {OP_WRPM, OP_WRDM})
                data_d = dbuf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            abuf_q  <= '0;
            dbuf_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            resp_q  <= '0;
            dout_q  <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            abuf_q  <= abuf_d;
            dbuf_q  <= dbuf_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
            dout_q  <= dout_d;
            left_q  <= left_d;
        end
    end

    assign tx_start  = state_q == TX;
    assign WrPM      = state_q == EXEC && {4'h0, op_q} == OP_WRPM;
    assign WrDM      = state_q == EXEC && {4'h0, op_q} == OP_WRDM;
    assign RdDM      = state_q == EXEC && {4'h0, op_q} == OP_RDDM;
    assign reset_bip = state_q == EXEC && {4'h0, op_q} == OP_RSTB;
    assign d_out     = dout_q;
    assign outAddr   = addr_q;
    assign outData   = data_q;
    assign leds      = {state_q, op_q};
endmodule

// File: tb/tb_bip_host_if.sv
// tb_bip_host_if: directed frames against a frame-level model of bip_host_if
module tb_bip_host_if;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 12;
    localparam int TIMEOUT_CYC = 20;

    typedef struct {
        int                k;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } stb_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        d_in = 8'h00;
    logic              rx_done = 1'b0;
    logic              tx_done = 1'b0;
    logic [DATA_W-1:0] inData;
    logic              tx_start;
    logic [7:0]        d_out;
    logic              WrPM, WrDM, RdDM, reset_bip;
    logic [ADDR_W-1:0] outAddr;
    logic [DATA_W-1:0] outData;
    logic [7:0]        leds;

    stb_t        exp_s[$];
    logic [7:0]  exp_t[$];
    logic [7:0]  txlog[$];
    logic [7:0]  fr[$];
    int          vecs = 0;
    int          errs = 0;
    int          k;
    stb_t        e;
    logic [7:0]  held;
    logic [15:0] rd_val = 16'h1234;
    logic        rd_pend = 1'b0;

    bip_host_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .rx_done(rx_done), .tx_done(tx_done),
        .inData(inData), .tx_start(tx_start), .d_out(d_out), .WrPM(WrPM), .WrDM(WrDM),
        .RdDM(RdDM), .reset_bip(reset_bip), .outAddr(outAddr), .outData(outData), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h, need %0h", nm, act, want);
        end
    endtask

    // Memory: read data appears exactly one cycle after RdDM, garbage otherwise.
    initial begin
        inData = 16'hDEAD;
        forever begin
            @(posedge clk);
            #1;
            inData  = rd_pend ? rd_val : 16'hDEAD;
            rd_pend = RdDM;
        end
    end

    // UART transmitter: finishes each byte three cycles after tx_start.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (tx_start) begin
                held = d_out;
                repeat (3) @(posedge clk);
                #1;
                if (!reset) chk("d_out hold", 32'(d_out), 32'(held));
                tx_done = 1'b1;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (WrPM || WrDM || RdDM || reset_bip) begin
                k = WrPM ? 1 : WrDM ? 2 : RdDM ? 3 : 4;
                chk("strobe onehot", 32'($countones({WrPM, WrDM, RdDM, reset_bip})), 1);
                if (exp_s.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL strobe: unexpected kind %0d, none required", k);
                end else begin
                    e = exp_s.pop_front();
                    chk("strobe kind", 32'(k), 32'(e.k));
                    if (k != 4) chk("outAddr", 32'(outAddr), 32'(e.a));
                    if (k < 3) chk("outData", 32'(outData), 32'(e.d));
                end
            end
            if (tx_start) begin
                txlog.push_back(d_out);
                if (exp_t.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL tx: unexpected byte %0h, none required", d_out);
                end else begin
                    chk("tx byte", 32'(d_out), 32'(exp_t.pop_front()));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        d_in    = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic send_all(input int gap);
        foreach (fr[i]) begin
            send_byte(fr[i]);
            repeat (gap) @(posedge clk);
        end
    endtask

    task automatic add_ck();
`ifdef BIP_HOST_IF_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        if (fr[0] inside {8'h01, 8'h02, 8'h03, 8'h04}) begin
            foreach (fr[i]) x ^= fr[i];
            fr.push_back(x);
        end
`endif
    endtask

    // Frame-level expectations from opcode semantics alone.
    task automatic model_frame();
        int op = int'(fr[0]);
`ifdef BIP_HOST_IF_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (fr[i]) x ^= fr[i];
        if (op >= 1 && op <= 4 && x != 8'h00) begin
            exp_t.push_back(8'hEE);
            return;
        end
`endif
        if (op == 1 || op == 2) begin
            exp_s.push_back('{op, 12'({fr[1], fr[2]}), {fr[3], fr[4]}});
            exp_t.push_back(8'h06);
        end else if (op == 3) begin
            exp_s.push_back('{3, 12'({fr[1], fr[2]}), 16'h0000});
            exp_t.push_back(rd_val[15:8]);
            exp_t.push_back(rd_val[7:0]);
        end else if (op == 4) begin
            exp_s.push_back('{4, 12'h000, 16'h0000});
            exp_t.push_back(8'h06);
        end else begin
            exp_t.push_back(8'h15);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_s.size() != 0 || exp_t.size() != 0 || leds[7:4] != 4'h0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("frame completes", 32'(n < 400), 1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int gap);
        add_ck();
        model_frame();
        send_all(gap);
        wait_done();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset strobes", 32'({tx_start, WrPM, WrDM, RdDM, reset_bip}), 0);
        chk("reset d_out", 32'(d_out), 0);
        chk("reset outAddr", 32'(outAddr), 0);
        chk("reset outData", 32'(outData), 0);
        chk("reset leds", 32'(leds), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        fr = '{8'h01, 8'h03, 8'h45, 8'hBE, 8'hEF};
        run_frame(1);
        chk("wrpm addr", 32'(outAddr), 32'h345);
        chk("wrpm data", 32'(outData), 32'hBEEF);
        chk("wrpm ack", 32'(txlog[$]), 32'h06);
        chk("wrpm leds", 32'(leds), 32'h01);
        rd_val = 16'h1234;
        fr = '{8'h03, 8'h00, 8'h10};
        run_frame(1);
        chk("rddm addr", 32'(outAddr), 32'h010);
        chk("rddm data held", 32'(outData), 32'hBEEF);
        chk("rddm hi", 32'(txlog[txlog.size()-2]), 32'h12);
        chk("rddm lo", 32'(txlog[$]), 32'h34);
        fr = '{8'h02, 8'hF1, 8'h23, 8'hCA, 8'hFE};
        run_frame(0);
        chk("wrdm addr trunc", 32'(outAddr), 32'h123);
        fr = '{8'h7F};
        run_frame(1);
        chk("nak byte", 32'(txlog[$]), 32'h15);
        chk("nak idle", 32'(leds[7:4]), 0);
        fr = '{8'h02, 8'h00};
        send_all(0);
        repeat (TIMEOUT_CYC - 2) @(posedge clk);
        #1;
        chk("timeout pending", 32'(leds[7:4] != 4'h0), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("timeout idle", 32'(leds[7:4]), 0);
        fr = '{8'h04};
        run_frame(1);
        chk("rstb ack", 32'(txlog[$]), 32'h06);
        fr = '{8'h01, 8'h0A, 8'hBC, 8'h12, 8'h34};
        run_frame(TIMEOUT_CYC - 4);
        chk("slow frame addr", 32'(outAddr), 32'hABC);
        fr = '{8'h04};
        add_ck();
        model_frame();
        send_all(0);
        send_byte(8'h7F);
        send_byte(8'h01);
        wait_done();
        rd_val = 16'hA55A;
        fr = '{8'h03, 8'h00, 8'h10};
        add_ck();
        exp_s.push_back('{3, 12'h010, 16'h0000});
        exp_t.push_back(8'hA5);
        send_all(1);
        begin
            int n = 0;
            while (!tx_start && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("abort reached tx", 32'(n < 100), 1);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort strobes", 32'({tx_start, WrPM, WrDM, RdDM, reset_bip}), 0);
        chk("abort d_out", 32'(d_out), 0);
        chk("abort outAddr", 32'(outAddr), 0);
        chk("abort outData", 32'(outData), 0);
        chk("abort leds", 32'(leds), 0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        chk("abort single byte", 32'(txlog[$]), 32'hA5);
        chk("abort queue", 32'(exp_s.size() + exp_t.size()), 0);
        fr = '{8'h04};
        run_frame(1);
`ifdef BIP_HOST_IF_CHECKSUM_EN
        fr = '{8'h04, 8'h04};
        exp_s.push_back('{4, 12'h000, 16'h0000});
        exp_t.push_back(8'h06);
        send_all(1);
        wait_done();
        chk("ck good ack", 32'(txlog[$]), 32'h06);
        fr = '{8'h04, 8'h05};
        exp_t.push_back(8'hEE);
        send_all(1);
        wait_done();
        chk("ck bad nak", 32'(txlog[$]), 32'hEE);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end
endmodule
